dmem_lsu: RTL

//  Load/store unit between the core control FSM and the data-memory bus.
//  - Turns the dmem_read/dmem_write strobes into one req/gnt/rvalid bus transaction.
//  - Generates byte enables and store-data lane replication.
//  - Extracts and sign/zero-extends load data; returns dmem_ready to the control FSM.
//  - Holds at most one transaction outstanding.

---
 rtl/dmem_lsu_pkg.sv | 39 +++
 rtl/dmem_lsu_if.sv | 28 ++
 rtl/dmem_lsu_lane_align.sv | 47 ++++
 rtl/dmem_lsu.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
//  - XLEN: data/address width (only 32 is supported).
//  - lsu_size_e: access size decoded from func3[1:0].
//  - lsu_state_e: bus transaction FSM states.
//  - ld_extend(): lane extraction plus sign/zero extension of load data.
package dmem_lsu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    // Shift the addressed lane down to bit 0, then extend per func3.
    // Word and the reserved encodings return the raw bus word.
    function automatic logic [XLEN-1:0] ld_extend(input logic [XLEN-1:0] rdata,
                                                  input logic [1:0]      off,
                                                  input logic [2:0]      f3);
        logic [XLEN-1:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  ld_extend = {{24{sh[7]}}, sh[7:0]};
            3'b100:  ld_extend = {24'h000000, sh[7:0]};
            3'b001:  ld_extend = {{16{sh[15]}}, sh[15:0]};
            3'b101:  ld_extend = {16'h0000, sh[15:0]};
            default: ld_extend = rdata;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Data-memory bus: single outstanding req/gnt/rvalid transaction.
//  master (LSU): drives bus_req, bus_we, bus_addr, bus_be, bus_wdata;
//                receives bus_gnt, bus_rvalid, bus_rdata, bus_err.
//  slave (memory): the mirror image.
interface dmem_lsu_if;
    import dmem_lsu_pkg::*;

    logic            bus_req;
    logic            bus_we;
    logic [XLEN-1:0] bus_addr;
    logic [3:0]      bus_be;
    logic [XLEN-1:0] bus_wdata;
    logic            bus_gnt;
    logic            bus_rvalid;
    logic [XLEN-1:0] bus_rdata;
    logic            bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err
    );

endinterface

// File: rtl/dmem_lsu_lane_align.sv
// Combinational lane alignment for the LSU.
//  func3_i      access type (inst[14:12])
//  off_i        byte offset addr[1:0]
//  store_data_i rs2 value
//  rdata_i      raw bus read data
//  be_o         byte enables for the access size/offset
//  wdata_o      lane-replicated store data
//  load_data_o  extracted and extended load result
module dmem_lsu_lane_align
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]      func3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] load_data_o
);

    // Byte enables and store replication; reserved sizes behave as word.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
        case (func3_i[1:0])
            BYTE: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            HALF: begin
                if (off_i[1]) begin
                    be_o = 4'b1100;
                end else begin
                    be_o = 4'b0011;
                end
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = store_data_i;
            end
        endcase
    end

    assign load_data_o = ld_extend(rdata_i, off_i, func3_i);

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the core control FSM and the data-memory bus.
//  clk, rst_n   clock; synchronous active-low reset
//  dmem_read    load strobe, held until dmem_ready
//  dmem_write   store strobe, held until dmem_ready (wins over dmem_read)
//  func3, addr, store_data, misalign   access description from the core
//  dmem_ready   one-cycle completion pulse
//  load_data    extended load result, held until the next load completes
//  access_fault pulses with dmem_ready when the bus reported an error
//  bus          master side of the data-memory bus
module dmem_lsu
    import dmem_lsu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dmem_read,
    input  logic            dmem_write,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    input  logic            misalign,
    output logic            dmem_ready,
    output logic [XLEN-1:0] load_data,
    output logic            access_fault,
    dmem_lsu_if.master      bus
);

    lsu_state_e      state_q, state_d;
    logic            req_q, we_q, ready_q, fault_q;
    logic [XLEN-1:0] addr_q, wdata_q, load_data_q;
    logic [3:0]      be_q;
    logic [2:0]      func3_q;
    logic [1:0]      off_q;

    logic [2:0]      al_func3_s;
    logic [1:0]      al_off_s;
    logic [3:0]      be_s;
    logic [XLEN-1:0] wdata_s, ld_s;
    logic            strobe_s;

    // Aligner sees live inputs while issuing and the latched access afterwards.
    always_comb begin
        if (state_q == IDLE) begin
            al_func3_s = func3;
            al_off_s   = addr[1:0];
        end else begin
            al_func3_s = func3_q;
            al_off_s   = off_q;
        end
    end

    dmem_lsu_lane_align u_align (
        .func3_i      (al_func3_s),
        .off_i        (al_off_s),
        .store_data_i (store_data),
        .rdata_i      (bus.bus_rdata),
        .be_o         (be_s),
        .wdata_o      (wdata_s),
        .load_data_o  (ld_s)
    );

    // The strobe that started this transaction; its drop means a trap abort.
    always_comb begin
        if (we_q) begin
            strobe_s = dmem_write;
        end else begin
            strobe_s = dmem_read;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if ((dmem_read || dmem_write) && !misalign) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (bus.bus_gnt) begin
                    state_d = RESP;
                end else begin
                    state_d = REQ;
                end
            end
            RESP: begin
                if (bus.bus_rvalid) begin
                    if (strobe_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = RESP;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; bus fields stay frozen after issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            addr_q      <= {XLEN{1'b0}};
            wdata_q     <= {XLEN{1'b0}};
            load_data_q <= {XLEN{1'b0}};
            be_q        <= 4'b0000;
            func3_q     <= 3'b000;
            off_q       <= 2'b00;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (state_d == REQ) begin
                        req_q   <= 1'b1;
                        we_q    <= dmem_write;
                        addr_q  <= {addr[XLEN-1:2], 2'b00};
                        off_q   <= addr[1:0];
                        func3_q <= func3;
                        be_q    <= be_s;
                        wdata_q <= wdata_s;
                    end
                end
                REQ: begin
                    if (bus.bus_gnt) begin
                        req_q <= 1'b0;
                    end
                end
                RESP: begin
                    if (bus.bus_rvalid && strobe_s) begin
                        ready_q <= 1'b1;
                        fault_q <= bus.bus_err;
                        if (!we_q) begin
                            load_data_q <= ld_s;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;
    assign dmem_ready    = ready_q;
    assign access_fault  = fault_q;
    assign load_data     = load_data_q;

endmodule
